// File: rtl/npc_ctrl.sv
// rtl/npc_ctrl.sv - next-PC / instruction sequencing controller
// Walks fetch, wait, decode, execute and writeback for each instruction, halting on ebreak, illegal opcode or fetch timeout.
module npc_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h8000_0000,
  parameter int          FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_req_addr,
  input  logic        ifu_resp_valid,
  input  logic [31:0] ifu_resp_inst,
  output logic [31:0] inst,
  input  logic [6:0]  opcode,
  output logic        alu_en,
  output logic        reg_wen,
  output logic [31:0] pc,
  output logic        halt,
  output logic [1:0]  halt_code,
  output logic [31:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_WAIT   = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] EBREAK    = 32'h0010_0073;

  localparam logic [1:0] HC_NONE    = 2'd0;
  localparam logic [1:0] HC_EBREAK  = 2'd1;
  localparam logic [1:0] HC_ILLEGAL = 2'd2;
  localparam logic [1:0] HC_TIMEOUT = 2'd3;

  state_t      state;
  logic [31:0] tcnt;
  logic        timeout_hit;

  // Fires on the FETCH_TIMEOUT-th cycle spent in FETCH plus WAIT.
  assign timeout_hit = (tcnt + 32'd1) == 32'(FETCH_TIMEOUT);

  // Strobes decode the state register only; rst masks them during the reset cycle.
  assign ifu_req_valid = (state == S_FETCH) && !rst;
  assign alu_en        = (state == S_EXEC)  && !rst;
  assign reg_wen       = (state == S_WB)    && !rst;
  assign halt          = (state == S_HALT);
  assign ifu_req_addr  = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      inst       <= 32'd0;
      retire_cnt <= 32'd0;
      halt_code  <= HC_NONE;
      tcnt       <= 32'd0;
    end else begin
      case (state)
        S_FETCH: begin
          if (timeout_hit) begin
            state     <= S_HALT;
            halt_code <= HC_TIMEOUT;
          end else begin
            tcnt <= tcnt + 32'd1;
            if (ifu_req_ready) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (timeout_hit) begin
            state     <= S_HALT;
            halt_code <= HC_TIMEOUT;
          end else begin
            tcnt <= tcnt + 32'd1;
            if (ifu_resp_valid) begin
              inst  <= ifu_resp_inst;
              state <= S_DECODE;
            end
          end
        end
        S_DECODE: begin
          if (opcode == OP_IMM) begin
            state <= S_EXEC;
          end else if (opcode == OP_SYSTEM && inst == EBREAK) begin
            state     <= S_HALT;
            halt_code <= HC_EBREAK;
          end else begin
            state     <= S_HALT;
            halt_code <= HC_ILLEGAL;
          end
        end
        S_EXEC: begin
          state <= S_WB;
        end
        S_WB: begin
          pc         <= pc + 32'd4;
          retire_cnt <= retire_cnt + 32'd1;
          tcnt       <= 32'd0;
          state      <= S_FETCH;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npc_ctrl.sv
// tb/tb_npc_ctrl.sv - directed self-checking bench for npc_ctrl
// Drives directed fetch/response sequences and checks outputs 1ns after each rising edge.
module tb_npc_ctrl;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_resp_inst;
  logic [31:0] inst;
  logic [6:0]  opcode;
  logic        alu_en;
  logic        reg_wen;
  logic [31:0] pc;
  logic        halt;
  logic [1:0]  halt_code;
  logic [31:0] retire_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Decoder stand-in: opcode field of the latched instruction.
  assign opcode = inst[6:0];

  npc_ctrl #(.RESET_PC(RPC), .FETCH_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_inst(ifu_resp_inst),
    .inst(inst), .opcode(opcode), .alu_en(alu_en), .reg_wen(reg_wen),
    .pc(pc), .halt(halt), .halt_code(halt_code), .retire_cnt(retire_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ifu_req_ready = 1'b0; ifu_resp_valid = 1'b0; ifu_resp_inst = 32'd0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Zero-wait fetch of one addi, checking every stage strobe and the retire result.
  task automatic run_addi(input logic [31:0] word, input logic [31:0] exp_pc, input logic [31:0] exp_ret);
    chk("fetch_valid", {31'd0, ifu_req_valid}, 32'd1);
    chk("fetch_addr", ifu_req_addr, exp_pc);
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0; ifu_resp_valid = 1'b1; ifu_resp_inst = word;
    chk("wait_valid", {31'd0, ifu_req_valid}, 32'd0);
    tick();
    ifu_resp_valid = 1'b0;
    chk("decode_inst", inst, word);
    chk("decode_strobes", {30'd0, alu_en, reg_wen}, 32'd0);
    tick();
    chk("exec_strobes", {29'd0, ifu_req_valid, alu_en, reg_wen}, 32'b010);
    tick();
    chk("wb_strobes", {29'd0, ifu_req_valid, alu_en, reg_wen}, 32'b001);
    chk("wb_pc", pc, exp_pc);
    tick();
    chk("next_fetch_valid", {31'd0, ifu_req_valid}, 32'd1);
    chk("next_pc", pc, exp_pc + 32'd4);
    chk("retire", retire_cnt, exp_ret);
  endtask

  initial begin
    rst = 1'b1; ifu_req_ready = 1'b0; ifu_resp_valid = 1'b1; ifu_resp_inst = 32'hFFFF_FFFF;
    tick();
    chk("rst_strobes", {29'd0, ifu_req_valid, alu_en, reg_wen}, 32'd0);
    chk("rst_pc", pc, RPC);
    chk("rst_inst", inst, 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);
    chk("rst_halt", {29'd0, halt, halt_code}, 32'd0);
    rst = 1'b0; ifu_resp_valid = 1'b0; ifu_resp_inst = 32'd0;
    #1;
    chk("post_rst_valid", {31'd0, ifu_req_valid}, 32'd1);

    // Single addi, then two more and an ebreak.
    run_addi(32'h0050_0093, RPC, 32'd1);
    run_addi(32'h0010_0113, RPC + 32'd4, 32'd2);
    run_addi(32'h0020_0193, RPC + 32'd8, 32'd3);
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0; ifu_resp_valid = 1'b1; ifu_resp_inst = 32'h0010_0073;
    tick();
    ifu_resp_valid = 1'b0;
    tick();
    chk("ebreak_halt", {29'd0, halt, halt_code}, {29'd0, 1'b1, 2'd1});
    chk("ebreak_pc", pc, 32'h8000_000C);
    chk("ebreak_retire", retire_cnt, 32'd3);
    ifu_req_ready = 1'b1; ifu_resp_valid = 1'b1; ifu_resp_inst = 32'h0050_0093;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_strobes", {29'd0, ifu_req_valid, alu_en, reg_wen}, 32'd0);
    end
    chk("halt_held", {29'd0, halt, halt_code}, {29'd0, 1'b1, 2'd1});
    chk("halt_inst_frozen", inst, 32'h0010_0073);
    chk("halt_pc_frozen", pc, 32'h8000_000C);

    // Illegal opcode 0110011.
    do_reset();
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0; ifu_resp_valid = 1'b1; ifu_resp_inst = 32'h0000_0033;
    tick();
    ifu_resp_valid = 1'b0;
    chk("illegal_decode_wen", {31'd0, reg_wen}, 32'd0);
    tick();
    chk("illegal_halt", {29'd0, halt, halt_code}, {29'd0, 1'b1, 2'd2});
    chk("illegal_pc", pc, RPC);
    chk("illegal_retire", retire_cnt, 32'd0);
    tick();
    chk("illegal_wen", {31'd0, reg_wen}, 32'd0);

    // Timeout with FETCH_TIMEOUT=8: ready asserted on the 8th cycle is ignored.
    do_reset();
    for (int i = 0; i < 7; i++) tick();
    chk("timeout_not_yet", {29'd0, halt, halt_code}, 32'd0);
    chk("timeout_still_req", {31'd0, ifu_req_valid}, 32'd1);
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    chk("timeout_halt", {29'd0, halt, halt_code}, {29'd0, 1'b1, 2'd3});
    chk("timeout_valid", {31'd0, ifu_req_valid}, 32'd0);
    chk("timeout_pc", pc, RPC);

    // Reset in WAIT with a response arriving that same cycle.
    do_reset();
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    rst = 1'b1; ifu_resp_valid = 1'b1; ifu_resp_inst = 32'h0050_0093;
    tick();
    chk("rst_wait_inst", inst, 32'd0);
    chk("rst_wait_pc", pc, RPC);
    chk("rst_wait_valid", {31'd0, ifu_req_valid}, 32'd0);
    rst = 1'b0; ifu_resp_valid = 1'b0;
    #1;
    chk("rst_wait_fresh_req", {31'd0, ifu_req_valid}, 32'd1);
    tick();

    // Early responses in FETCH and in the accept cycle are ignored.
    ifu_resp_valid = 1'b1; ifu_resp_inst = 32'h0070_0113;
    tick();
    chk("early_resp_inst", inst, 32'd0);
    chk("early_resp_fetch", {31'd0, ifu_req_valid}, 32'd1);
    ifu_req_ready = 1'b1; ifu_resp_inst = 32'h0030_0213;
    tick();
    ifu_req_ready = 1'b0; ifu_resp_valid = 1'b0;
    chk("accept_resp_inst", inst, 32'd0);
    chk("accept_wait", {31'd0, ifu_req_valid}, 32'd0);
    tick();
    chk("wait_idle_inst", inst, 32'd0);
    ifu_resp_valid = 1'b1; ifu_resp_inst = 32'h00A0_0093;
    tick();
    ifu_resp_valid = 1'b0;
    chk("wait_resp_inst", inst, 32'h00A0_0093);
    tick();
    chk("late_exec", {31'd0, alu_en}, 32'd1);
    tick();
    tick();
    chk("late_pc", pc, RPC + 32'd4);
    chk("late_retire", retire_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
